multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle successor to the single-cycle opcode decoder. Moore FSM that sequences RV32I
//  R/I-ALU/load/store/branch/JAL instructions over several cycles. Drives the shared datapath
//  (single memory port, one ALU, IR/PC enables). Stalls on a memory-ready handshake, with an
//  optional timeout. Flags illegal opcodes and counts retired instructions.
// PARAMETERS
//  CNT_W        32  width of retired-instruction counter
//  MEM_TIMEOUT  0   max wait cycles on mem_ready before abort; 0 = wait forever
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  opcode       in   7      instr[6:0] from IR (valid from DECODE onward)
//  mem_ready    in   1      memory access completes this cycle
//  pc_update    out  1      PC write enable (fetch increment or JAL)
//  branch       out  1      PC write if ALU zero
//  adr_src      out  1      0=PC, 1=ALU result register
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  ir_write     out  1      IR/oldPC write enable
//  result_src   out  2      00=ALUOut, 01=mem data, 10=ALU result
//  aluop        out  2      00=add, 01=sub/compare, 10=funct-decoded
//  alu_src_a    out  2      00=PC, 01=oldPC, 10=rs1
//  alu_src_b    out  2      00=rs2, 01=imm, 10=const 4
//  reg_write    out  1      register-file write enable
//  illegal_op   out  1      1-cycle pulse, unsupported opcode
//  mem_timeout  out  1      1-cycle pulse, access aborted
//  retired      out  CNT_W  instructions completed (wraps 2^CNT_W-1 -> 0)
//  state_o      out  4      current state encoding, for debug
// BEHAVIOUR
//  - rst_n low (async): state=FETCH, retired=0, wait counter=0.
//    All control outputs forced 0 while rst_n is low. First fetch starts on the first edge after release.
//  - Moore outputs. Any signal not listed for a state is 0. Encodings are given in the order listed.
//    FETCH(0): adr_src=0, mem_read, srcA=00, srcB=10, aluop=00, result_src=10.
//      ir_write and pc_update = mem_ready. Next state: DECODE on mem_ready, else stay.
//    DECODE(1): srcA=01, srcB=01, aluop=00 (branch target). Next state by opcode:
//      0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I;
//      1100011 -> BEQ; 1101111 -> JAL; otherwise -> ILLEGAL.
//    MEMADR(2): srcA=10, srcB=01, aluop=00. Next: MEMREAD if opcode=0000011, else MEMWRITE.
//    MEMREAD(3): adr_src=1, mem_read, result_src=00. Next: MEMWB on mem_ready.
//    MEMWB(4): result_src=01, reg_write. Next: FETCH, retire.
//    MEMWRITE(5): adr_src=1, mem_write, result_src=00. Next: FETCH on mem_ready, retire.
//    EXEC_R(6): srcA=10, srcB=00, aluop=10. Next: ALUWB.
//    EXEC_I(7): srcA=10, srcB=01, aluop=10. Next: ALUWB.
//    ALUWB(8): result_src=00, reg_write. Next: FETCH, retire.
//    BEQ(9): srcA=10, srcB=00, aluop=01, result_src=00, branch. Next: FETCH, retire.
//    JAL(10): srcA=01, srcB=10, aluop=00, result_src=00, pc_update. Next: ALUWB.
//    ILLEGAL(11): illegal_op=1. Next: FETCH, no retire.
//  - Retire: retired increments on the edge leaving the state marked "retire".
//    JAL retires once, via ALUWB.
//  - Wait states (FETCH, MEMREAD, MEMWRITE): requests are held stable until mem_ready.
//    The wait counter clears on entry to any state and increments each cycle mem_ready=0.
//    If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready=0:
//      mem_timeout pulses for 1 cycle, next state is FETCH, no retire, no ir_write/reg_write.
//      If mem_ready=1 in that same cycle, mem_ready wins and there is no timeout.
//  - Latency with mem_ready always 1: R/I/load/store/branch/JAL = 4/4/5/4/3/4 cycles.
//  - Reset asserted mid-instruction aborts immediately. No partial retire.
// TESTING
//  1 mem_ready=1; opcode 0110011: FETCH,DECODE,EXEC_R,ALUWB. reg_write in cycle 4 only; retired 0->1.
//  2 load 0000011, mem_ready low 3 cycles in MEMREAD: mem_read, adr_src=1 held 4 cycles. MEMWB, retired+1.
//  3 store 0100011: mem_write only in MEMWRITE. reg_write never 1. Back to FETCH, retired+1.
//  4 opcode 1111111: ILLEGAL. illegal_op pulse of 1 cycle, retired unchanged, next state FETCH.
//  5 MEM_TIMEOUT=4, mem_ready=0 in FETCH: mem_timeout pulses after 4 wait cycles. ir_write never 1.
//  6 CNT_W=4 with retired=15, BEQ: retired wraps to 0. Assert rst_n low mid-EXEC_R: outputs 0, state_o=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch/decode/execute over a shared
// datapath, with memory-ready stalls, optional access timeout and a retired-instruction counter.
module multicycle_control_fsm #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_update,
    output logic             branch,
    output logic             adr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       aluop,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // The abort fires on the edge that would make the wait count equal MEM_TIMEOUT.
    localparam logic        TO_EN  = (MEM_TIMEOUT > 0) ? 1'b1 : 1'b0;
    localparam logic [15:0] TO_LIM = (MEM_TIMEOUT > 0) ? 16'(MEM_TIMEOUT - 1) : 16'd0;

    state_t            state_r;
    state_t            state_next_s;
    logic [15:0]       wait_cnt_r;
    logic [CNT_W-1:0]  retired_r;
    logic              mem_timeout_r;
    logic              wait_state_s;
    logic              timeout_hit_s;
    logic              retire_s;

    assign wait_state_s  = (state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE);
    assign timeout_hit_s = TO_EN && wait_state_s && !mem_ready && (wait_cnt_r == TO_LIM);

    // Next-state and retire decision
    always_comb begin
        state_next_s = state_r;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) state_next_s = S_DECODE;
                else           state_next_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
                    OP_R:              state_next_s = S_EXEC_R;
                    OP_I:              state_next_s = S_EXEC_I;
                    OP_BEQ:            state_next_s = S_BEQ;
                    OP_JAL:            state_next_s = S_JAL;
                    default:           state_next_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LOAD) state_next_s = S_MEMREAD;
                else                   state_next_s = S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready) state_next_s = S_MEMWB;
                else           state_next_s = S_MEMREAD;
            end
            S_MEMWB: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_EXEC_R:  state_next_s = S_ALUWB;
            S_EXEC_I:  state_next_s = S_ALUWB;
            S_ALUWB: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_BEQ: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_JAL:     state_next_s = S_ALUWB;
            S_ILLEGAL: state_next_s = S_FETCH;
            default:   state_next_s = S_FETCH;
        endcase
        if (timeout_hit_s) begin
            state_next_s = S_FETCH;
            retire_s     = 1'b0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register, wait counter, retire counter and timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_FETCH;
            wait_cnt_r    <= 16'd0;
            retired_r     <= {CNT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            mem_timeout_r <= timeout_hit_s;
            if (timeout_hit_s || (state_next_s != state_r)) begin
                wait_cnt_r <= 16'd0;
            end else if (wait_state_s && !mem_ready && (wait_cnt_r != 16'hFFFF)) begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Moore output decode; held at zero while reset is asserted
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        aluop      = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        if (!rst_n) begin
            pc_update = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_update  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    aluop     = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    aluop     = 2'b10;
                end
                S_ALUWB:   reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a = 2'b10;
                    aluop     = 2'b01;
                    branch    = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_update = 1'b1;
                end
                S_ILLEGAL: illegal_op = 1'b1;
                default:   illegal_op = 1'b0;
            endcase
        end
    end

    assign mem_timeout = mem_timeout_r;
    assign retired     = retired_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction expected state paths and a
// control-word table built from the instruction-level behaviour, plus an infinite-wait instance.
module tb_multicycle_control_fsm;

    localparam int TO_B = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;

    logic       pc_update, branch, adr_src, mem_read, mem_write, ir_write;
    logic [1:0] result_src, aluop, alu_src_a, alu_src_b;
    logic       reg_write, illegal_op, mem_timeout;
    logic [3:0] retired;
    logic [3:0] state_o;

    logic        pc_update_i, branch_i, adr_src_i, mem_read_i, mem_write_i, ir_write_i;
    logic [1:0]  result_src_i, aluop_i, alu_src_a_i, alu_src_b_i;
    logic        reg_write_i, illegal_op_i, mem_timeout_i;
    logic [31:0] retired_i;
    logic [3:0]  state_o_i;

    int   checks = 0;
    int   errors = 0;
    int   exp_ret = 0;
    logic pending_to = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.CNT_W(4), .MEM_TIMEOUT(TO_B)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_update(pc_update), .branch(branch), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src), .aluop(aluop),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .retired(retired), .state_o(state_o)
    );

    multicycle_control_fsm #(.CNT_W(32), .MEM_TIMEOUT(0)) dut_inf (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_update(pc_update_i), .branch(branch_i), .adr_src(adr_src_i), .mem_read(mem_read_i),
        .mem_write(mem_write_i), .ir_write(ir_write_i), .result_src(result_src_i), .aluop(aluop_i),
        .alu_src_a(alu_src_a_i), .alu_src_b(alu_src_b_i), .reg_write(reg_write_i),
        .illegal_op(illegal_op_i), .mem_timeout(mem_timeout_i), .retired(retired_i), .state_o(state_o_i)
    );

    // {pc_update, branch, adr_src, mem_read, mem_write, ir_write, result_src, aluop, src_a, src_b,
    //  reg_write, illegal_op, mem_timeout}
    function automatic logic [16:0] ctrl_of(input int st, input logic mr, input logic to);
        logic [16:0] c;
        case (st)
            0:  c = {mr,   1'b0, 1'b0, 1'b1, 1'b0, mr,   2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
            1:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
            2:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
            3:  c = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
            4:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
            5:  c = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
            6:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
            7:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
            8:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
            9:  c = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
            10: c = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0};
            11: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
            default: c = 17'd0;
        endcase
        c[0] = to;
        return c;
    endfunction

    function automatic logic [16:0] got_ctrl();
        return {pc_update, branch, adr_src, mem_read, mem_write, ir_write, result_src, aluop,
                alu_src_a, alu_src_b, reg_write, illegal_op, mem_timeout};
    endfunction

    task automatic step(input int st, input logic mr);
        logic [20:0] exp_v;
        logic [20:0] got_v;
        mem_ready = mr;
        @(negedge clk);
        exp_v = {4'(st), ctrl_of(st, mr, pending_to)};
        got_v = {state_o, got_ctrl()};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL ctrl st=%0d mr=%0b: got %h expected %h", st, mr, got_v, exp_v);
        end
        checks++;
        if (retired !== 4'(exp_ret)) begin
            errors++;
            $display("FAIL retired st=%0d: got %0d expected %0d", st, retired, exp_ret);
        end
        pending_to = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int st, input int stall, output logic aborted);
        aborted = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step(st, 1'b0);
            if (i + 1 == TO_B) begin
                aborted    = 1'b1;
                pending_to = 1'b1;
                return;
            end
        end
        step(st, 1'b1);
    endtask

    task automatic retire_one();
        exp_ret = (exp_ret + 1) % 16;
    endtask

    task automatic run_instr(input logic [6:0] op, input int fstall, input int mstall);
        logic ab;
        opcode = op;
        wait_step(0, fstall, ab);
        if (ab) return;
        step(1, 1'($urandom));
        case (op)
            OP_LOAD: begin
                step(2, 1'($urandom));
                wait_step(3, mstall, ab);
                if (ab) return;
                step(4, 1'($urandom));
                retire_one();
            end
            OP_STORE: begin
                step(2, 1'($urandom));
                wait_step(5, mstall, ab);
                if (ab) return;
                retire_one();
            end
            OP_R: begin
                step(6, 1'($urandom));
                step(8, 1'($urandom));
                retire_one();
            end
            OP_I: begin
                step(7, 1'($urandom));
                step(8, 1'($urandom));
                retire_one();
            end
            OP_BEQ: begin
                step(9, 1'($urandom));
                retire_one();
            end
            OP_JAL: begin
                step(10, 1'($urandom));
                step(8, 1'($urandom));
                retire_one();
            end
            default: step(11, 1'($urandom));
        endcase
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({state_o, got_ctrl(), retired} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {state_o, got_ctrl(), retired});
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        mem_ready  = 1'b0;
        exp_ret    = 0;
        pending_to = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        run_instr(OP_R, 0, 0);
        run_instr(OP_LOAD, 0, 3);
        run_instr(OP_STORE, 0, 0);
        run_instr(OP_BAD, 0, 0);
        run_instr(OP_I, 1, 0);
        run_instr(OP_JAL, 0, 0);
        run_instr(OP_BEQ, 2, 0);
    endtask

    task automatic test_timeout();
        do_reset();
        run_instr(OP_R, 6, 0);
        run_instr(OP_R, 0, 0);
        run_instr(OP_LOAD, 0, 5);
        run_instr(OP_STORE, 0, 4);
        run_instr(OP_STORE, 3, 3);
    endtask

    task automatic test_no_timeout();
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({state_o_i, mem_timeout_i, ir_write_i, pc_update_i} !== 7'd0) begin
                errors++;
                $display("FAIL inf_wait cycle %0d: got %h expected 0", i,
                         {state_o_i, mem_timeout_i, ir_write_i, pc_update_i});
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ir_write_i, pc_update_i} !== 2'b11) begin
            errors++;
            $display("FAIL inf_ready: got %b expected 11", {ir_write_i, pc_update_i});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (state_o_i !== 4'd1) begin
            errors++;
            $display("FAIL inf_decode: got %0d expected 1", state_o_i);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) run_instr(OP_R, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_R, 0, 0);
    endtask

    task automatic test_reset_mid();
        run_instr(OP_R, 0, 0);
        opcode = OP_R;
        step(0, 1'b1);
        step(1, 1'b1);
        mem_ready = 1'b1;
        #2;
        checks++;
        if (state_o !== 4'd6) begin
            errors++;
            $display("FAIL mid_exec_state: got %0d expected 6", state_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state_o, got_ctrl(), retired} !== 25'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h expected 0", {state_o, got_ctrl(), retired});
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        mem_ready  = 1'b0;
        exp_ret    = 0;
        pending_to = 1'b0;
        run_instr(OP_I, 0, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [7];
        logic [6:0] op;
        ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_R; ops[3] = OP_I;
        ops[4] = OP_BEQ;  ops[5] = OP_JAL;   ops[6] = OP_BAD;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else                           op = ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 5), $urandom_range(0, 5));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_no_timeout();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
